// File: rtl/alu_op_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU op sequencer and the functional units it
// drives: sequencer state encoding, the two opcodes the sequencer handles
// itself, and the unit opcodes broadcast on the shared unit_op bus.
// ----------------------------------------------------------------------------
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      DRAIN     = 2'd3
   } seq_state_e;

   // Opcodes consumed by the sequencer itself (never strobed to the units)
   localparam logic [3:0] OP_NOP     = 4'h0;
   localparam logic [3:0] OP_LDI     = 4'h1;

   // Unit opcodes, shared with the functional units
   localparam logic [3:0] OP_AND_IMM = 4'hC;
   localparam logic [3:0] OP_OR_IMM  = 4'hD;
   localparam logic [3:0] OP_XOR_IMM = 4'hE;

   // True when the opcode must be issued to a functional unit
   function automatic logic is_unit_op(input logic [3:0] op);
      return (op != OP_NOP) && (op != OP_LDI);
   endfunction

endpackage : alu_seq_pkg

// File: rtl/alu_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_seq_if
// Bundles the instruction handshake, the functional-unit bus and the
// sequencer status outputs.
//   master : the sequencer (accepts instructions, drives unit bus and status)
//   slave  : the environment (decode stage + functional units)
// Signals:
//   instr_valid/instr_ready/instr_op/instr_imm : instruction handshake
//   unit_op/unit_data1/unit_data2              : strobe + operands to units
//   unit_out/unit_done                         : result + done from unit
//   acc/res_valid/busy/err                     : accumulator and status
// ----------------------------------------------------------------------------
interface alu_seq_if;

   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_op;
   logic [7:0] instr_imm;
   logic [3:0] unit_op;
   logic [7:0] unit_data1;
   logic [7:0] unit_data2;
   logic [7:0] unit_out;
   logic       unit_done;
   logic [7:0] acc;
   logic       res_valid;
   logic       busy;
   logic       err;

   modport master (
      input  instr_valid, instr_op, instr_imm, unit_out, unit_done,
      output instr_ready, unit_op, unit_data1, unit_data2,
             acc, res_valid, busy, err
   );

   modport slave (
      output instr_valid, instr_op, instr_imm, unit_out, unit_done,
      input  instr_ready, unit_op, unit_data1, unit_data2,
             acc, res_valid, busy, err
   );

endinterface : alu_seq_if

// File: rtl/alu_op_sequencer_watchdog.sv
// ----------------------------------------------------------------------------
// seq_watchdog
// Loadable down-counter shared by the WAIT_DONE and DRAIN phases.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (counter -> 0)
//   clr_i       : restart the count from load_val_i
//   load_val_i  : starting count (limit - 1)
//   en_i        : decrement one step (saturates at zero)
//   expire_o    : count has reached zero
// ----------------------------------------------------------------------------
module seq_watchdog #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: restart has priority over counting down
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != {W{1'b0}})) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == {W{1'b0}});

endmodule : seq_watchdog

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
// Issues one ALU instruction at a time to the 8-bit functional units and owns
// the accumulator. NOP and LDI are handled locally; any other opcode is
// strobed for one cycle on unit_op, the result is captured when unit_done
// rises, and the next instruction is accepted only after unit_done falls.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_seq_if master (handshake, unit bus, acc and status)
// ----------------------------------------------------------------------------
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int         TIMEOUT   = 8,
   parameter int         DRAIN_MAX = 8,
   parameter logic [7:0] ACC_INIT  = 8'h00
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.master bus
);

   localparam int CNT_MAX = (TIMEOUT > DRAIN_MAX) ? TIMEOUT : DRAIN_MAX;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   seq_state_e       state_q, state_d;
   logic [7:0]       acc_q, acc_d;
   logic [3:0]       unit_op_q, unit_op_d;
   logic [7:0]       data1_q, data1_d;
   logic [7:0]       data2_q, data2_d;
   logic             res_valid_q, res_valid_d;
   logic             err_q, err_d;

   logic             wd_clr_s;
   logic             wd_en_s;
   logic [CNT_W-1:0] wd_val_s;
   logic             wd_expire_s;

   seq_watchdog #(.W(CNT_W)) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (wd_clr_s),
      .load_val_i (wd_val_s),
      .en_i       (wd_en_s),
      .expire_o   (wd_expire_s)
   );

   // Next-state, accumulator and strobe logic
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      unit_op_d   = OP_NOP;     // strobe lasts exactly one cycle, else the unit re-fires
      data1_d     = data1_q;
      data2_d     = data2_q;
      res_valid_d = 1'b0;
      err_d       = err_q;
      wd_clr_s    = 1'b0;
      wd_en_s     = 1'b0;
      wd_val_s    = CNT_W'(TIMEOUT - 1);

      case (state_q)
         IDLE: begin
            if (bus.instr_valid) begin
               if (bus.instr_op == OP_LDI) begin
                  acc_d       = bus.instr_imm;
                  res_valid_d = 1'b1;
               end else if (is_unit_op(bus.instr_op)) begin
                  // Operands are latched here so they are stable during ISSUE
                  state_d   = ISSUE;
                  unit_op_d = bus.instr_op;
                  data1_d   = acc_q;
                  data2_d   = bus.instr_imm;
                  wd_clr_s  = 1'b1;
                  wd_val_s  = CNT_W'(TIMEOUT - 1);
               end else begin
                  state_d = IDLE;   // NOP: consumed without effect
               end
            end else begin
               state_d = IDLE;
            end
         end

         ISSUE: begin
            state_d = WAIT_DONE;
         end

         WAIT_DONE: begin
            // X/Z on unit_done falls into the not-done branch
            if (bus.unit_done == 1'b1) begin
               acc_d       = bus.unit_out;
               res_valid_d = 1'b1;
               state_d     = DRAIN;
               wd_clr_s    = 1'b1;
               wd_val_s    = CNT_W'(DRAIN_MAX - 1);
            end else if (wd_expire_s) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               wd_en_s = 1'b1;
            end
         end

         DRAIN: begin
            if (bus.unit_done != 1'b1) begin
               state_d = IDLE;
            end else if (wd_expire_s) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               wd_en_s = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, accumulator and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= ACC_INIT;
         unit_op_q   <= OP_NOP;
         data1_q     <= 8'h00;
         data2_q     <= 8'h00;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         unit_op_q   <= unit_op_d;
         data1_q     <= data1_d;
         data2_q     <= data2_d;
         res_valid_q <= res_valid_d;
         err_q       <= err_d;
      end
   end

   assign bus.instr_ready = (state_q == IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.unit_op     = unit_op_q;
   assign bus.unit_data1  = data1_q;
   assign bus.unit_data2  = data2_q;
   assign bus.acc         = acc_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.err         = err_q;

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench with a timeline model of each instruction (accept edge T,
// capture and release edges derived from the unit behaviour) and a per-cycle
// compare process, plus hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   localparam int TIMEOUT   = 8;
   localparam int DRAIN_MAX = 8;
   localparam int HOLD      = 3;
   localparam int M_NORMAL  = 0;
   localparam int M_SILENT  = 1;
   localparam int M_STUCK   = 2;

   logic clk = 1'b0;
   logic rst;
   alu_seq_if bus();

   alu_op_sequencer #(
      .TIMEOUT   (TIMEOUT),
      .DRAIN_MAX (DRAIN_MAX),
      .ACC_INIT  (8'h00)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- functional unit model ----------------
   int         unit_mode   = M_NORMAL;
   int         unit_cnt    = 0;
   int         strobe_seen = 0;
   logic [7:0] unit_out_r  = 8'h00;

   always @(posedge clk) begin
      if (bus.unit_op != OP_NOP) begin
         unit_out_r <= bus.unit_data1 | bus.unit_data2;
         unit_cnt   <= HOLD;
      end else if (unit_cnt != 0) begin
         unit_cnt <= unit_cnt - 1;
      end
      if (bus.unit_op == OP_OR_IMM) strobe_seen <= strobe_seen + 1;
      if ($isunknown(bus.unit_done)) $display("warning: unit_done unknown at %0t", $time);
   end

   assign bus.unit_out  = unit_out_r;
   assign bus.unit_done = (unit_mode == M_STUCK) || ((unit_mode == M_NORMAL) && (unit_cnt != 0));

   // ---------------- timeline model ----------------
   int         cyc = 0;
   bit         model_ok = 1'b0;
   logic       m_busy, m_err, m_rv;
   logic [7:0] m_acc, m_d1, m_d2, m_cap;
   logic [3:0] m_op;
   int         t_cap, t_end;
   bit         t_fail;

   always @(posedge clk) begin
      cyc++;
      m_rv = 1'b0;
      m_op = OP_NOP;
      if (rst) begin
         model_ok = 1'b1;
         m_busy = 1'b0; m_err = 1'b0; m_acc = 8'h00; m_d1 = 8'h00; m_d2 = 8'h00;
      end else if (!m_busy) begin
         if (bus.instr_valid && bus.instr_op == OP_LDI) begin
            m_acc = bus.instr_imm;
            m_rv  = 1'b1;
         end else if (bus.instr_valid && bus.instr_op != OP_NOP) begin
            m_op   = bus.instr_op;
            m_d1   = m_acc;
            m_d2   = bus.instr_imm;
            m_cap  = m_acc | bus.instr_imm;
            m_busy = 1'b1;
            case (unit_mode)
               M_SILENT: begin t_cap = -1;      t_end = cyc + 1 + TIMEOUT;   t_fail = 1'b1; end
               M_STUCK:  begin t_cap = cyc + 2; t_end = cyc + 2 + DRAIN_MAX; t_fail = 1'b1; end
               default:  begin t_cap = cyc + 2; t_end = cyc + 2 + HOLD;      t_fail = 1'b0; end
            endcase
         end
      end else begin
         if (cyc == t_cap) begin m_acc = m_cap; m_rv = 1'b1; end
         if (cyc == t_end) begin m_busy = 1'b0; if (t_fail) m_err = 1'b1; end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      if (model_ok) begin
         chk("ready",     int'(bus.instr_ready), int'(!m_busy));
         chk("busy",      int'(bus.busy),        int'(m_busy));
         chk("unit_op",   int'(bus.unit_op),     int'(m_op));
         chk("data1",     int'(bus.unit_data1),  int'(m_d1));
         chk("data2",     int'(bus.unit_data2),  int'(m_d2));
         chk("acc",       int'(bus.acc),         int'(m_acc));
         chk("res_valid", int'(bus.res_valid),   int'(m_rv));
         chk("err",       int'(bus.err),         int'(m_err));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Offer an instruction; returns at the negedge after the accepting edge
   task automatic send(input logic [3:0] op, input logic [7:0] imm);
      bit ok = 1'b0;
      bus.instr_valid = 1'b1;
      bus.instr_op    = op;
      bus.instr_imm   = imm;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (bus.instr_ready) ok = 1'b1;
         @(negedge clk);
      end
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL accept_timeout: op %0h never accepted", op);
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (bus.instr_ready) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL idle_timeout: instr_ready stayed low");
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   int base;

   initial begin
      rst = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr_op    = OP_NOP;
      bus.instr_imm   = 8'h00;
      tick(2);
      rst = 1'b0;
      chk("rst_acc", int'(bus.acc), 8'h00);
      chk("rst_op",  int'(bus.unit_op), 4'h0);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_rdy", int'(bus.instr_ready), 1);
      chk("rst_rv",  int'(bus.res_valid), 0);

      // LDI then OR with a normal unit
      send(OP_LDI, 8'h0F);
      bus.instr_valid = 1'b0;
      chk("ldi_acc", int'(bus.acc), 8'h0F);
      chk("ldi_rv",  int'(bus.res_valid), 1);
      chk("model_ldi", int'(m_acc), 8'h0F);
      base = strobe_seen;
      send(OP_OR_IMM, 8'hF0);            // now after edge T
      bus.instr_valid = 1'b0;
      chk("or_strobe", int'(bus.unit_op), 4'hD);
      tick(1);                            // T+1
      chk("or_strobe_gone", int'(bus.unit_op), 4'h0);
      tick(1);                            // T+2
      chk("or_acc", int'(bus.acc), 8'hFF);
      chk("or_rv",  int'(bus.res_valid), 1);
      chk("model_or", int'(m_acc), 8'hFF);
      tick(1);                            // T+3
      chk("or_rv_once", int'(bus.res_valid), 0);
      chk("or_done_hi", int'(bus.unit_done), 1);
      chk("or_rdy_hold", int'(bus.instr_ready), 0);
      tick(1);                            // T+4
      chk("or_done_lo", int'(bus.unit_done), 0);
      chk("or_rdy_drain", int'(bus.instr_ready), 0);
      tick(1);                            // T+5
      chk("or_rdy_back", int'(bus.instr_ready), 1);
      chk("or_refire", strobe_seen - base, 1);

      // No done: timeout abort
      unit_mode = M_SILENT;
      send(OP_OR_IMM, 8'h11);
      bus.instr_valid = 1'b0;
      tick(8);                            // T+8
      chk("to_err_early", int'(bus.err), 0);
      chk("to_busy", int'(bus.busy), 1);
      tick(1);                            // T+9
      chk("to_err", int'(bus.err), 1);
      chk("to_rdy", int'(bus.instr_ready), 1);
      chk("to_acc", int'(bus.acc), 8'hFF);

      // Done stuck high: capture, then drain abort
      pulse_reset();
      unit_mode = M_STUCK;
      send(OP_LDI, 8'h3C);
      send(OP_OR_IMM, 8'h03);
      bus.instr_valid = 1'b0;
      tick(2);                            // T+2
      chk("stk_acc", int'(bus.acc), 8'h3F);
      chk("stk_rv",  int'(bus.res_valid), 1);
      tick(7);                            // T+9
      chk("stk_err_early", int'(bus.err), 0);
      chk("stk_busy", int'(bus.busy), 1);
      tick(1);                            // T+10
      chk("stk_err", int'(bus.err), 1);
      chk("stk_rdy", int'(bus.instr_ready), 1);

      // Reset during WAIT_DONE (err is still set from the stuck test)
      unit_mode = M_SILENT;
      send(OP_LDI, 8'h77);
      send(OP_OR_IMM, 8'h01);
      bus.instr_valid = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid_acc", int'(bus.acc), 8'h00);
      chk("mid_op",  int'(bus.unit_op), 4'h0);
      chk("mid_err", int'(bus.err), 0);
      chk("mid_rdy", int'(bus.instr_ready), 1);
      chk("mid_rv",  int'(bus.res_valid), 0);

      // Reset during ISSUE: the unit still fires, its done must be ignored
      unit_mode = M_NORMAL;
      send(OP_LDI, 8'h12);
      send(OP_OR_IMM, 8'h80);
      bus.instr_valid = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(2);
      chk("iss_done_seen", int'(bus.unit_done), 1);
      tick(3);
      chk("iss_acc", int'(bus.acc), 8'h00);

      // Back-to-back with instr_valid held high
      base = strobe_seen;
      send(OP_NOP, 8'h00);
      chk("b2b_nop_rv", int'(bus.res_valid), 0);
      chk("b2b_nop_op", int'(bus.unit_op), 4'h0);
      send(OP_LDI, 8'hA5);
      chk("b2b_ldi_acc", int'(bus.acc), 8'hA5);
      send(OP_OR_IMM, 8'h5A);
      bus.instr_valid = 1'b0;
      chk("b2b_d1", int'(bus.unit_data1), 8'hA5);
      wait_idle();
      chk("b2b_acc", int'(bus.acc), 8'hFF);
      chk("b2b_refire", strobe_seen - base, 1);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule : tb_alu_op_sequencer
